// File: rtl/dispatch_ctl.sv
// dispatch_ctl
//   Moves decoded instructions from decode into the ROB and the per-FU
//   reservation stations (ALU, LS). Downstream capacity is tracked with
//   credits instead of a ready signal. A small skid FIFO holds instructions
//   between decode and dispatch and back-pressures decode when it is full.
//   Dispatch stops after an HLT instruction is dispatched. A mispredict flush
//   discards all buffered work and returns every credit to its full value.
//
// Ports
//   in_clk, in_rst_n                 clock (rising edge), async active-low reset
//   in_dec_valid / out_dec_ready     decode handshake
//   in_dec_fu_id                     target FU: 0 = ALU, 1 = LS
//   in_dec_is_hlt                    instruction is HLT
//   in_dec_payload                   opaque decoded fields, passed through
//   out_disp_valid                   dispatch fires this cycle
//   out_disp_fu_id, out_disp_payload FIFO head (zero when the FIFO is empty)
//   in_rob_commit                    one ROB entry freed
//   in_alu_rs_free, in_ls_rs_free    one RS entry freed in that station
//   in_flush                         mispredict: discard all, restore credits
//   out_rob_credits                  current ROB credit count
//   out_halted                       HLT dispatched, dispatch frozen
//   out_credit_err                   sticky: a credit came back while at max
//
// Handshake: an instruction moves from decode into the FIFO on any rising edge
// where in_dec_valid and out_dec_ready are both high. out_dec_ready never looks
// at in_dec_valid, and a pop in the same cycle never raises it. On the
// dispatch side there is no ready: out_disp_valid high means the head
// instruction has been consumed at the next edge and its credits are spent.

module dispatch_ctl #(
  parameter int ROB_SIZE    = 16,
  parameter int ALU_RS_SIZE = 4,
  parameter int LS_RS_SIZE  = 4,
  parameter int BUF_DEPTH   = 2,
  parameter int PAYLOAD_W   = 128
) (
  input  logic                          in_clk,
  input  logic                          in_rst_n,
  input  logic                          in_dec_valid,
  input  logic                          in_dec_fu_id,
  input  logic                          in_dec_is_hlt,
  input  logic [PAYLOAD_W-1:0]          in_dec_payload,
  output logic                          out_dec_ready,
  output logic                          out_disp_valid,
  output logic                          out_disp_fu_id,
  output logic [PAYLOAD_W-1:0]          out_disp_payload,
  input  logic                          in_rob_commit,
  input  logic                          in_alu_rs_free,
  input  logic                          in_ls_rs_free,
  input  logic                          in_flush,
  output logic [$clog2(ROB_SIZE+1)-1:0] out_rob_credits,
  output logic                          out_halted,
  output logic                          out_credit_err
);

  localparam int RW = $clog2(ROB_SIZE + 1);
  localparam int AW = $clog2(ALU_RS_SIZE + 1);
  localparam int LW = $clog2(LS_RS_SIZE + 1);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  localparam logic [RW-1:0] ROB_MAX = RW'(ROB_SIZE);
  localparam logic [AW-1:0] ALU_MAX = AW'(ALU_RS_SIZE);
  localparam logic [LW-1:0] LS_MAX  = LW'(LS_RS_SIZE);
  localparam logic [CW-1:0] BUF_MAX = CW'(BUF_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_HALTED  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_next;
  logic [RW-1:0]   rob_cred_q, rob_cred_next;
  logic [AW-1:0]   alu_cred_q, alu_cred_next;
  logic [LW-1:0]   ls_cred_q, ls_cred_next;
  logic            rob_err, alu_err, ls_err;
  logic            halted_q, credit_err_q;

  // FIFO storage; contents are only meaningful below count_q, so no reset.
  logic [PAYLOAD_W-1:0] buf_payload [BUF_DEPTH];
  logic                 buf_fu      [BUF_DEPTH];
  logic                 buf_hlt     [BUF_DEPTH];

  logic empty, push, fire, fire_alu, fire_ls;
  logic head_fu, head_hlt, rs_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    empty         = (count_q == '0);
    out_dec_ready = (state_q == ST_RUN) && (count_q < BUF_MAX);
    push          = in_dec_valid && out_dec_ready;
    head_fu       = empty ? 1'b0 : buf_fu[rd_ptr_q];
    head_hlt      = empty ? 1'b0 : buf_hlt[rd_ptr_q];
    rs_ok         = head_fu ? (ls_cred_q != '0) : (alu_cred_q != '0);
    fire          = (state_q == ST_RUN) && !empty && (rob_cred_q != '0) && rs_ok;
    fire_alu      = fire && !head_fu;
    fire_ls       = fire && head_fu;

    out_disp_valid   = fire;
    out_disp_fu_id   = head_fu;
    out_disp_payload = empty ? '0 : buf_payload[rd_ptr_q];
    out_rob_credits  = rob_cred_q;
    out_halted       = halted_q;
    out_credit_err   = credit_err_q;
  end

  always_comb begin
    count_next = count_q;
    case ({push, fire})
      2'b10:   count_next = count_q + CW'(1);
      2'b01:   count_next = count_q - CW'(1);
      default: count_next = count_q;
    endcase
  end

  // Credit update: spend on fire, return on free. Fire and free together
  // cancel. A return while already full saturates and flags an error.
  always_comb begin
    rob_cred_next = rob_cred_q;
    rob_err       = 1'b0;
    case ({fire, in_rob_commit})
      2'b10: rob_cred_next = rob_cred_q - RW'(1);
      2'b01: begin
        if (rob_cred_q == ROB_MAX) rob_err = 1'b1;
        else                       rob_cred_next = rob_cred_q + RW'(1);
      end
      default: rob_cred_next = rob_cred_q;
    endcase

    alu_cred_next = alu_cred_q;
    alu_err       = 1'b0;
    case ({fire_alu, in_alu_rs_free})
      2'b10: alu_cred_next = alu_cred_q - AW'(1);
      2'b01: begin
        if (alu_cred_q == ALU_MAX) alu_err = 1'b1;
        else                       alu_cred_next = alu_cred_q + AW'(1);
      end
      default: alu_cred_next = alu_cred_q;
    endcase

    ls_cred_next = ls_cred_q;
    ls_err       = 1'b0;
    case ({fire_ls, in_ls_rs_free})
      2'b10: ls_cred_next = ls_cred_q - LW'(1);
      2'b01: begin
        if (ls_cred_q == LS_MAX) ls_err = 1'b1;
        else                     ls_cred_next = ls_cred_q + LW'(1);
      end
      default: ls_cred_next = ls_cred_q;
    endcase
  end

  always_ff @(posedge in_clk) begin
    if (push) begin
      buf_payload[wr_ptr_q] <= in_dec_payload;
      buf_fu[wr_ptr_q]      <= in_dec_fu_id;
      buf_hlt[wr_ptr_q]     <= in_dec_is_hlt;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q      <= ST_RUN;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      rob_cred_q   <= ROB_MAX;
      alu_cred_q   <= ALU_MAX;
      ls_cred_q    <= LS_MAX;
      halted_q     <= 1'b0;
      credit_err_q <= 1'b0;
    end else if (in_flush) begin
      // Frees arriving with the flush are dropped: credits return to full.
      state_q    <= ST_RECOVER;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      rob_cred_q <= ROB_MAX;
      alu_cred_q <= ALU_MAX;
      ls_cred_q  <= LS_MAX;
      halted_q   <= 1'b0;
    end else begin
      rob_cred_q <= rob_cred_next;
      alu_cred_q <= alu_cred_next;
      ls_cred_q  <= ls_cred_next;
      if (rob_err || alu_err || ls_err) credit_err_q <= 1'b1;

      case (state_q)
        ST_RUN: begin
          if (fire && head_hlt) begin
            // Everything behind the HLT, including a same-cycle push, is dropped.
            state_q  <= ST_HALTED;
            halted_q <= 1'b1;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
          end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (fire) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_next;
          end
        end
        ST_HALTED:  state_q <= ST_HALTED;
        ST_RECOVER: state_q <= ST_RUN;
        default:    state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_dispatch_ctl.sv
// Directed bench for dispatch_ctl with default parameters (ROB 16, ALU 4,
// LS 4, FIFO depth 2). Inputs change 1 time unit after the rising edge,
// outputs are checked 1 unit later, well before the next edge.

module tb_dispatch_ctl;

  logic         in_clk;
  logic         in_rst_n;
  logic         in_dec_valid;
  logic         in_dec_fu_id;
  logic         in_dec_is_hlt;
  logic [127:0] in_dec_payload;
  logic         out_dec_ready;
  logic         out_disp_valid;
  logic         out_disp_fu_id;
  logic [127:0] out_disp_payload;
  logic         in_rob_commit;
  logic         in_alu_rs_free;
  logic         in_ls_rs_free;
  logic         in_flush;
  logic [4:0]   out_rob_credits;
  logic         out_halted;
  logic         out_credit_err;

  int n_total = 0;
  int n_bad   = 0;
  logic [127:0] exp_q[$];

  dispatch_ctl dut (
    .in_clk           (in_clk),
    .in_rst_n         (in_rst_n),
    .in_dec_valid     (in_dec_valid),
    .in_dec_fu_id     (in_dec_fu_id),
    .in_dec_is_hlt    (in_dec_is_hlt),
    .in_dec_payload   (in_dec_payload),
    .out_dec_ready    (out_dec_ready),
    .out_disp_valid   (out_disp_valid),
    .out_disp_fu_id   (out_disp_fu_id),
    .out_disp_payload (out_disp_payload),
    .in_rob_commit    (in_rob_commit),
    .in_alu_rs_free   (in_alu_rs_free),
    .in_ls_rs_free    (in_ls_rs_free),
    .in_flush         (in_flush),
    .out_rob_credits  (out_rob_credits),
    .out_halted       (out_halted),
    .out_credit_err   (out_credit_err)
  );

  // ---------------- clock / reset ----------------
  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_idle();
    in_dec_valid   = 1'b0;
    in_dec_fu_id   = 1'b0;
    in_dec_is_hlt  = 1'b0;
    in_dec_payload = '0;
    in_rob_commit  = 1'b0;
    in_alu_rs_free = 1'b0;
    in_ls_rs_free  = 1'b0;
    in_flush       = 1'b0;
  endtask

  // Reset is asserted between edges, so the checks below see the async path.
  task automatic do_reset(input string tag);
    drive_idle();
    in_rst_n = 1'b0;
    settle();
    check({tag, "_rst_valid"}, out_disp_valid, 1'b0);
    check({tag, "_rst_halted"}, out_halted, 1'b0);
    check({tag, "_rst_err"}, out_credit_err, 1'b0);
    check({tag, "_rst_rob"}, out_rob_credits, 5'd16);
    repeat (2) tick();
    in_rst_n = 1'b1;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic drive_dec(input logic fu, input logic hlt, input logic [127:0] pl);
    in_dec_valid   = 1'b1;
    in_dec_fu_id   = fu;
    in_dec_is_hlt  = hlt;
    in_dec_payload = pl;
  endtask

  function automatic logic [127:0] pl_of(input int i);
    return {32'hC0DE_0000, 32'(i), 32'hFFFF_0000 ^ 32'(i), 32'(i * 7 + 1)};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic expect_disp(input string tag, input logic fu);
    logic [127:0] e;
    check({tag, "_valid"}, out_disp_valid, 1'b1);
    check({tag, "_fu"}, out_disp_fu_id, fu);
    check({tag, "_qhas"}, 128'(exp_q.size() != 0), 128'(1));
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_payload"}, out_disp_payload, e);
    end
  endtask

  // ---------------- tests ----------------
  initial begin
    drive_idle();
    in_rst_n = 1'b1;
    #2;

    // T1: reset values, single ALU instruction, one-cycle latency.
    do_reset("t1");
    settle();
    check("t1_ready0", out_dec_ready, 1'b1);
    check("t1_fu0", out_disp_fu_id, 1'b0);
    check("t1_pl0", out_disp_payload, 128'd0);
    drive_dec(1'b0, 1'b0, pl_of(100));
    settle();
    check("t1_nobypass", out_disp_valid, 1'b0);
    exp_q.push_back(pl_of(100));
    tick();
    drive_idle();
    settle();
    expect_disp("t1_disp", 1'b0);
    check("t1_rob_before", out_rob_credits, 5'd16);
    tick();
    check("t1_rob_after", out_rob_credits, 5'd15);
    check("t1_idle", out_disp_valid, 1'b0);

    // T2: ALU credits run out, FIFO fills, one free releases the 5th.
    do_reset("t2");
    for (int i = 0; i < 6; i++) begin
      drive_dec(1'b0, 1'b0, pl_of(i));
      settle();
      check("t2_ready", out_dec_ready, 1'b1);
      if (i >= 1 && i <= 4) expect_disp("t2_disp", 1'b0);
      else check("t2_nodisp", out_disp_valid, 1'b0);
      exp_q.push_back(pl_of(i));
      tick();
    end
    drive_idle();
    settle();
    check("t2_full_ready", out_dec_ready, 1'b0);
    check("t2_blocked", out_disp_valid, 1'b0);
    check("t2_rob12", out_rob_credits, 5'd12);
    in_alu_rs_free = 1'b1;
    tick();
    drive_idle();
    settle();
    expect_disp("t2_fifth", 1'b0);
    check("t2_pop_noready", out_dec_ready, 1'b0);
    tick();
    check("t2_ready_back", out_dec_ready, 1'b1);
    check("t2_sixth_blocked", out_disp_valid, 1'b0);
    check("t2_rob11", out_rob_credits, 5'd11);

    // T3: LS head with no LS credits blocks a following ALU instruction.
    do_reset("t3");
    for (int i = 0; i < 6; i++) begin
      drive_dec((i < 5) ? 1'b1 : 1'b0, 1'b0, pl_of(200 + i));
      settle();
      if (i >= 1 && i <= 4) expect_disp("t3_disp", 1'b1);
      else check("t3_nodisp", out_disp_valid, 1'b0);
      exp_q.push_back(pl_of(200 + i));
      tick();
    end
    drive_idle();
    settle();
    check("t3_hol0", out_disp_valid, 1'b0);
    check("t3_rob12", out_rob_credits, 5'd12);
    tick();
    check("t3_hol1", out_disp_valid, 1'b0);
    in_ls_rs_free = 1'b1;
    tick();
    drive_idle();
    settle();
    expect_disp("t3_ls", 1'b1);
    tick();
    expect_disp("t3_alu", 1'b0);
    tick();
    check("t3_done", out_disp_valid, 1'b0);
    check("t3_rob10", out_rob_credits, 5'd10);

    // T4: HLT freezes dispatch and drops the trailing ALU; flush recovers.
    do_reset("t4");
    drive_dec(1'b0, 1'b1, pl_of(300));
    settle();
    check("t4_nodisp0", out_disp_valid, 1'b0);
    exp_q.push_back(pl_of(300));
    tick();
    drive_dec(1'b0, 1'b0, pl_of(301));
    settle();
    expect_disp("t4_hlt", 1'b0);
    check("t4_ready1", out_dec_ready, 1'b1);
    check("t4_nothalted", out_halted, 1'b0);
    tick();
    drive_idle();
    settle();
    check("t4_halted", out_halted, 1'b1);
    check("t4_ready_h", out_dec_ready, 1'b0);
    check("t4_nodisp_h", out_disp_valid, 1'b0);
    check("t4_rob15", out_rob_credits, 5'd15);
    tick();
    check("t4_still_halted", out_halted, 1'b1);
    check("t4_still_nodisp", out_disp_valid, 1'b0);
    in_flush = 1'b1;
    tick();
    drive_idle();
    settle();
    check("t4_rec_ready", out_dec_ready, 1'b0);
    check("t4_rec_halted", out_halted, 1'b0);
    check("t4_rec_disp", out_disp_valid, 1'b0);
    tick();
    check("t4_run_ready", out_dec_ready, 1'b1);
    check("t4_run_disp", out_disp_valid, 1'b0);
    check("t4_rob16", out_rob_credits, 5'd16);

    // T5: flush with two buffered entries and ROB credits at 10.
    do_reset("t5");
    for (int i = 0; i < 8; i++) begin
      drive_dec((i == 4 || i == 5) ? 1'b1 : 1'b0, 1'b0, pl_of(400 + i));
      settle();
      check("t5_ready", out_dec_ready, 1'b1);
      if (i >= 1 && i <= 6) expect_disp("t5_disp", (i == 5 || i == 6) ? 1'b1 : 1'b0);
      else check("t5_nodisp", out_disp_valid, 1'b0);
      if (i < 6) exp_q.push_back(pl_of(400 + i));
      tick();
    end
    drive_idle();
    settle();
    check("t5_full", out_dec_ready, 1'b0);
    check("t5_rob10", out_rob_credits, 5'd10);
    in_flush       = 1'b1;
    in_rob_commit  = 1'b1;
    in_alu_rs_free = 1'b1;
    tick();
    drive_idle();
    settle();
    check("t5_empty", out_disp_valid, 1'b0);
    check("t5_pl_zero", out_disp_payload, 128'd0);
    check("t5_rob16", out_rob_credits, 5'd16);
    check("t5_rec_ready", out_dec_ready, 1'b0);
    check("t5_noerr", out_credit_err, 1'b0);
    tick();
    check("t5_ready_back", out_dec_ready, 1'b1);

    // T6: fire plus commit cancels; commit at max saturates and sets error.
    do_reset("t6");
    drive_dec(1'b0, 1'b0, pl_of(500));
    exp_q.push_back(pl_of(500));
    tick();
    drive_idle();
    in_rob_commit = 1'b1;
    settle();
    expect_disp("t6_disp", 1'b0);
    tick();
    drive_idle();
    settle();
    check("t6_cancel_rob", out_rob_credits, 5'd16);
    check("t6_cancel_err", out_credit_err, 1'b0);
    in_rob_commit = 1'b1;
    tick();
    drive_idle();
    settle();
    check("t6_sat_rob", out_rob_credits, 5'd16);
    check("t6_err", out_credit_err, 1'b1);
    repeat (3) tick();
    check("t6_err_sticky", out_credit_err, 1'b1);
    do_reset("t6_end");
    settle();
    check("t6_err_cleared", out_credit_err, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
